// File: rtl/debug_pkg.sv
// Shared types and constants for the debug run-control block and its dump serializer.
package debug_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CONT,
      STEP,
      STEP_PULSE,
      DUMP
   } state_t;

   typedef enum logic [2:0] {
      SER_IDLE,
      LOAD,
      CAPTURE,
      SEND_BYTE,
      WAIT_TX,
      WAIT_RDY
   } ser_phase_t;

   typedef enum logic {
      RET_IDLE,
      RET_STEP
   } ret_t;

   localparam logic [7:0] CMD_RUN  = 8'h63;
   localparam logic [7:0] CMD_STEP = 8'h73;
   localparam logic [7:0] CMD_NEXT = 8'h6E;
   localparam logic [7:0] CMD_EXIT = 8'h65;

   function automatic int selWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dump_serializer.sv
// Walks NUM_WORDS datapath words and pushes each one MSB byte first through the
// UART TX handshake. A start pulse begins a dump, a done pulse ends it.
//
// phase     | meaning
// SER_IDLE  | waiting for start
// LOAD      | dump_sel presented, waitingForReg high
// CAPTURE   | latch dump_data; send its MSB byte at once if TX is ready
// SEND_BYTE | send current MSB byte once tx_ready
// WAIT_TX   | one cycle after tx_start so TX can drop tx_ready
// WAIT_RDY  | last byte of word handed off; wait for TX before next word / done
module dump_serializer import debug_pkg::*; #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 16,
   parameter int CNT_W     = 8,
   localparam int SEL_W    = selWidth(NUM_WORDS)
) (
   input  logic              clock,
   input  logic              resetGral,
   input  logic              start,
   input  logic              tx_ready,
   input  logic [WORD_W-1:0] dump_data,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic [SEL_W-1:0]  dump_sel,
   output logic [CNT_W-1:0]  sendCounter,
   output logic              waitingForReg,
   output logic              done
);

   localparam int BYTES = WORD_W / 8;
   localparam int BW    = $clog2(BYTES + 1);
   localparam logic [BW-1:0]    BYTES_PER_WORD = BW'(BYTES);
   localparam logic [SEL_W-1:0] WORD_LAST      = SEL_W'(NUM_WORDS - 1);

   ser_phase_t        phase;
   logic [WORD_W-1:0] shiftReg;
   logic [BW-1:0]     byteIdx;

   always_ff @(posedge clock) begin
      if (resetGral) begin
         phase         <= SER_IDLE;
         shiftReg      <= '0;
         byteIdx       <= '0;
         dump_sel      <= '0;
         sendCounter   <= '0;
         tx_start      <= 1'b0;
         tx_data       <= '0;
         waitingForReg <= 1'b0;
         done          <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         case (phase)
            SER_IDLE: if (start) begin
               dump_sel      <= '0;
               sendCounter   <= '0;
               waitingForReg <= 1'b1;
               phase         <= LOAD;
            end
            LOAD: begin
               waitingForReg <= 1'b0;
               byteIdx       <= '0;
               phase         <= CAPTURE;
            end
            CAPTURE: if (tx_ready) begin
               tx_start    <= 1'b1;
               tx_data     <= dump_data[WORD_W-1 -: 8];
               shiftReg    <= dump_data << 8;
               byteIdx     <= BW'(1);
               sendCounter <= sendCounter + 1'b1;
               phase       <= WAIT_TX;
            end else begin
               shiftReg <= dump_data;
               phase    <= SEND_BYTE;
            end
            SEND_BYTE: if (tx_ready) begin
               tx_start    <= 1'b1;
               tx_data     <= shiftReg[WORD_W-1 -: 8];
               shiftReg    <= shiftReg << 8;
               byteIdx     <= byteIdx + 1'b1;
               sendCounter <= sendCounter + 1'b1;
               phase       <= WAIT_TX;
            end
            WAIT_TX: phase <= (byteIdx == BYTES_PER_WORD) ? WAIT_RDY : SEND_BYTE;
            default: if (tx_ready) begin
               if (dump_sel == WORD_LAST) begin
                  done     <= 1'b1;
                  dump_sel <= '0;
                  phase    <= SER_IDLE;
               end else begin
                  dump_sel      <= dump_sel + 1'b1;
                  waitingForReg <= 1'b1;
                  phase         <= LOAD;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/debug_unit_ctrl.sv
// Run-control for the debug top level: decodes UART commands into idle / run / step
// modes, gates the pipeline, and triggers a register dump after each step and at halt.
//
// state      | meaning
// IDLE       | pipeline stopped, waiting for 'c' or 's'
// CONT       | free running until halt_in
// STEP       | step mode, waiting for 'n' or 'e'
// STEP_PULSE | single pipe_enable cycle (suppressed if already halted)
// DUMP       | dump_serializer busy (its LOAD/SEND_BYTE/WAIT_TX), then return target
module debug_unit_ctrl import debug_pkg::*; #(
   parameter int WORD_W    = 32,
   parameter int NUM_WORDS = 16,
   parameter int CNT_W     = 8,
   localparam int SEL_W    = selWidth(NUM_WORDS)
) (
   input  logic              clock,
   input  logic              resetGral,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   input  logic              tx_ready,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   input  logic              halt_in,
   output logic [SEL_W-1:0]  dump_sel,
   input  logic [WORD_W-1:0] dump_data,
   output logic              pipe_enable,
   output logic              ledIdle,
   output logic              ledStep,
   output logic              ledSend,
   output logic              ledCont,
   output logic [CNT_W-1:0]  sendCounter,
   output logic              sentFlag,
   output logic              waitingForReg
);

   localparam logic [3:0] LED_IDLE = 4'b1000;
   localparam logic [3:0] LED_STEP = 4'b0100;
   localparam logic [3:0] LED_SEND = 4'b0010;
   localparam logic [3:0] LED_CONT = 4'b0001;

   state_t     state;
   ret_t       retTarget;
   logic       serStart;
   logic       serDone;
   logic [3:0] ledVec;

   assign {ledIdle, ledStep, ledSend, ledCont} = ledVec;

   always_ff @(posedge clock) begin
      if (resetGral) begin
         state       <= IDLE;
         retTarget   <= RET_IDLE;
         pipe_enable <= 1'b0;
         serStart    <= 1'b0;
         sentFlag    <= 1'b0;
         ledVec      <= LED_IDLE;
      end else begin
         serStart <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_valid && (rx_data == CMD_RUN)) begin
                  state       <= CONT;
                  pipe_enable <= 1'b1;
                  sentFlag    <= 1'b0;
                  ledVec      <= LED_CONT;
               end else if (rx_valid && (rx_data == CMD_STEP)) begin
                  state    <= STEP;
                  sentFlag <= 1'b0;
                  ledVec   <= LED_STEP;
               end
            end
            // halt has priority; any byte arriving here is simply not looked at
            CONT: if (halt_in) begin
               state       <= DUMP;
               retTarget   <= RET_IDLE;
               pipe_enable <= 1'b0;
               serStart    <= 1'b1;
               ledVec      <= LED_SEND;
            end
            STEP: begin
               if (rx_valid && (rx_data == CMD_NEXT)) begin
                  state       <= STEP_PULSE;
                  retTarget   <= RET_STEP;
                  pipe_enable <= ~halt_in;
                  serStart    <= 1'b1;
               end else if (rx_valid && (rx_data == CMD_EXIT)) begin
                  state  <= IDLE;
                  ledVec <= LED_IDLE;
               end
            end
            STEP_PULSE: begin
               state       <= DUMP;
               pipe_enable <= 1'b0;
               ledVec      <= LED_SEND;
            end
            default: if (serDone) begin
               sentFlag <= 1'b1;
               if (retTarget == RET_STEP) begin
                  state  <= STEP;
                  ledVec <= LED_STEP;
               end else begin
                  state  <= IDLE;
                  ledVec <= LED_IDLE;
               end
            end
         endcase
      end
   end

   dump_serializer #(
      .WORD_W    (WORD_W),
      .NUM_WORDS (NUM_WORDS),
      .CNT_W     (CNT_W)
   ) u_ser (
      .clock         (clock),
      .resetGral     (resetGral),
      .start         (serStart),
      .tx_ready      (tx_ready),
      .dump_data     (dump_data),
      .tx_start      (tx_start),
      .tx_data       (tx_data),
      .dump_sel      (dump_sel),
      .sendCounter   (sendCounter),
      .waitingForReg (waitingForReg),
      .done          (serDone)
   );

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// Bench for debug_unit_ctrl: 4 x 32-bit dump, UART TX model with 10-cycle busy.
module tb_debug_unit_ctrl;

   localparam int WORD_W    = 32;
   localparam int NUM_WORDS = 4;
   localparam int CNT_W     = 8;
   localparam int BYTES     = WORD_W / 8;
   localparam int TOTAL     = NUM_WORDS * BYTES;

   localparam logic [7:0] K_RUN  = 8'h63;
   localparam logic [7:0] K_STEP = 8'h73;
   localparam logic [7:0] K_NEXT = 8'h6E;
   localparam logic [7:0] K_EXIT = 8'h65;

   logic              clock = 1'b0;
   logic              resetGral = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              halt_in = 1'b0;
   logic              tx_ready;
   logic              tx_start;
   logic [7:0]        tx_data;
   logic [1:0]        dump_sel;
   logic [WORD_W-1:0] dump_data;
   logic              pipe_enable, ledIdle, ledStep, ledSend, ledCont;
   logic [CNT_W-1:0]  sendCounter;
   logic              sentFlag, waitingForReg;

   logic [WORD_W-1:0] mem [NUM_WORDS];
   logic              holdTx = 1'b0;
   int                busy = 0;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] expQ[$];
   int         byteCount = 0;
   int         peCount = 0;
   logic       prevStart = 1'b0;
   int         mode = 0;   // 0 idle, 1 run, 2 step

   debug_unit_ctrl #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .CNT_W(CNT_W)) dut (
      .clock(clock), .resetGral(resetGral), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_start(tx_start), .tx_data(tx_data), .halt_in(halt_in),
      .dump_sel(dump_sel), .dump_data(dump_data), .pipe_enable(pipe_enable),
      .ledIdle(ledIdle), .ledStep(ledStep), .ledSend(ledSend), .ledCont(ledCont),
      .sendCounter(sendCounter), .sentFlag(sentFlag), .waitingForReg(waitingForReg)
   );

   always #5 clock = ~clock;

   assign dump_data = mem[dump_sel];
   assign tx_ready  = (busy == 0) && !holdTx;

   always @(posedge clock) begin
      if (tx_start) busy <= 10;
      else if (busy > 0) busy <= busy - 1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Per-cycle scoreboard: byte stream, handshake rules, counters, LED one-hotness.
   always @(negedge clock) begin
      if (!resetGral) begin
         chk("led_onehot", 64'(int'(ledIdle) + int'(ledStep) + int'(ledSend) + int'(ledCont)), 64'd1);
         if (tx_start) begin
            chk("tx_start_gap", 64'(prevStart), 64'd0);
            chk("tx_start_while_ready", 64'(tx_ready), 64'd1);
            chk("tx_byte_expected", 64'(expQ.size() > 0), 64'd1);
            if (expQ.size() > 0) chk("tx_byte", 64'(tx_data), 64'(expQ.pop_front()));
            byteCount++;
            chk("sendCounter_live", 64'(sendCounter), 64'(CNT_W'(byteCount)));
         end
         if (waitingForReg) chk("dump_sel_order", 64'(dump_sel), 64'(byteCount / BYTES));
         if (pipe_enable) peCount++;
      end
      prevStart = tx_start;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic pushDump();
      for (int w = 0; w < NUM_WORDS; w++)
         for (int b = 0; b < BYTES; b++)
            expQ.push_back(8'(mem[w] >> (WORD_W - 8 - 8 * b)));
      byteCount = 0;
   endtask

   task automatic waitDump(input string name);
      int n;
      n = 0;
      while (!ledSend && n < 50) begin tick(); n++; end
      chk({name, "_dump_started"}, 64'(ledSend), 64'd1);
      n = 0;
      while (ledSend && n < 4000) begin tick(); n++; end
      chk({name, "_dump_ended"}, 64'(ledSend), 64'd0);
      chk({name, "_bytes_left"}, 64'(expQ.size()), 64'd0);
   endtask

   task automatic waitBytes(input int target);
      int n;
      n = 0;
      while (byteCount < target && n < 2000) begin tick(); n++; end
      chk("wait_bytes_reached", 64'(byteCount), 64'(target));
   endtask

   task automatic checkMode(input string name);
      logic [3:0] e;
      e = (mode == 0) ? 4'b1000 : (mode == 1) ? 4'b0001 : 4'b0100;
      chk(name, 64'({ledIdle, ledStep, ledSend, ledCont}), 64'(e));
   endtask

   task automatic randomMem();
      for (int i = 0; i < NUM_WORDS; i++) mem[i] = $urandom;
   endtask

   initial begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] = 32'h11223344 + i;
      tick(2);
      chk("rst_leds", 64'({ledIdle, ledStep, ledSend, ledCont}), 64'h8);
      chk("rst_outputs", 64'({tx_start, pipe_enable, sentFlag, waitingForReg}), 64'h0);
      chk("rst_counters", 64'({sendCounter, dump_sel}), 64'h0);
      resetGral = 1'b0;
      tick();

      // step and dump with the fixed pattern
      sendByte(K_STEP);
      mode = 2;
      checkMode("step_entered");
      peCount = 0;
      pushDump();
      chk("model_byte0", 64'(expQ[0]), 64'h11);
      chk("model_byte7", 64'(expQ[7]), 64'h45);
      chk("model_byte15", 64'(expQ[15]), 64'h47);
      sendByte(K_NEXT);
      chk("step_pe_t1", 64'(pipe_enable), 64'd1);
      tick();
      chk("step_pe_t2", 64'(pipe_enable), 64'd0);
      chk("step_load_t2", 64'({waitingForReg, dump_sel}), 64'h4);
      tick();
      chk("step_tx_t3", 64'(tx_start), 64'd0);
      tick();
      chk("step_tx_t4", 64'({tx_start, tx_data}), 64'h111);
      waitDump("step");
      chk("step_pe_count", 64'(peCount), 64'd1);
      chk("step_sendCounter", 64'(sendCounter), 64'(TOTAL));
      chk("step_sentFlag", 64'(sentFlag), 64'd1);
      checkMode("step_back_in_step");

      // exit step mode; 'n' in idle does nothing
      sendByte(K_EXIT);
      mode = 0;
      checkMode("exit_idle");
      peCount = 0;
      sendByte(K_NEXT);
      tick(10);
      chk("exit_no_pe", 64'(peCount), 64'd0);
      checkMode("exit_still_idle");
      sendByte(8'h78);
      tick(3);
      chk("x_no_pe", 64'(peCount), 64'd0);
      checkMode("x_still_idle");

      // continuous run to halt, with a 'c' arriving mid-dump
      peCount = 0;
      sendByte(K_RUN);
      mode = 1;
      checkMode("cont_entered");
      tick(49);
      halt_in = 1'b1;
      pushDump();
      chk("cont_pe_at_halt", 64'(pipe_enable), 64'd1);
      tick();
      chk("cont_pe_after_halt", 64'(pipe_enable), 64'd0);
      waitBytes(5);
      sendByte(K_RUN);
      waitDump("cont");
      halt_in = 1'b0;
      mode = 0;
      checkMode("cont_back_idle");
      chk("cont_pe_count", 64'(peCount), 64'd50);
      chk("cont_sendCounter", 64'(sendCounter), 64'(TOTAL));
      chk("cont_sentFlag", 64'(sentFlag), 64'd1);

      // backpressure mid-word
      sendByte(K_STEP);
      mode = 2;
      pushDump();
      sendByte(K_NEXT);
      waitBytes(2);
      holdTx = 1'b1;
      tick(100);
      chk("bp_no_progress", 64'(byteCount), 64'd2);
      holdTx = 1'b0;
      waitDump("bp");
      chk("bp_sendCounter", 64'(sendCounter), 64'(TOTAL));

      // reset mid-dump after byte 7
      randomMem();
      pushDump();
      sendByte(K_NEXT);
      waitBytes(7);
      resetGral = 1'b1;
      tick();
      resetGral = 1'b0;
      expQ.delete();
      byteCount = 0;
      mode = 0;
      checkMode("rstmid_leds");
      chk("rstmid_outputs", 64'({tx_start, pipe_enable, sentFlag, waitingForReg}), 64'h0);
      chk("rstmid_counters", 64'({sendCounter, dump_sel}), 64'h0);
      tick(12);

      // randomized command sequence
      for (int r = 0; r < 25; r++) begin
         logic [7:0] b;
         int k;
         int runLen;
         k = $urandom_range(0, 5);
         case (k)
            0:       b = K_RUN;
            1:       b = K_STEP;
            2, 3:    b = K_NEXT;
            4:       b = K_EXIT;
            default: b = 8'($urandom);
         endcase
         randomMem();
         peCount = 0;
         if (mode == 0 && b == K_RUN) begin
            runLen = $urandom_range(1, 30);
            sendByte(b);
            tick(runLen - 1);
            halt_in = 1'b1;
            pushDump();
            tick();
            waitDump("rnd_cont");
            halt_in = 1'b0;
            chk("rnd_cont_pe", 64'(peCount), 64'(runLen));
            chk("rnd_cont_sent", 64'({sentFlag, sendCounter}), 64'({1'b1, CNT_W'(TOTAL)}));
         end else if (mode == 2 && b == K_NEXT) begin
            pushDump();
            sendByte(b);
            waitDump("rnd_step");
            chk("rnd_step_pe", 64'(peCount), 64'd1);
            chk("rnd_step_sent", 64'({sentFlag, sendCounter}), 64'({1'b1, CNT_W'(TOTAL)}));
         end else begin
            sendByte(b);
            if (mode == 0 && b == K_STEP) mode = 2;
            else if (mode == 2 && b == K_EXIT) mode = 0;
            tick(2);
            chk("rnd_no_pe", 64'(peCount), 64'd0);
         end
         tick();
         checkMode("rnd_mode");
      end

      tick(15);
      chk("final_queue_empty", 64'(expQ.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/debug_unit_ctrl.md
# debug_unit_ctrl

Parametrised run-control and register-dump controller between the UART byte interfaces and the datapath in the debug top level. It decodes command bytes into idle, continuous-run and single-step modes, gates the pipeline with a clock enable, and serialises `NUM_WORDS` datapath words of `WORD_W` bits onto the UART TX byte interface after every step and at program halt. It generalises the fixed-width mode LEDs and send counter into one configurable block with a TX handshake and explicit halt handling.

## Interface

**Parameters**
- `WORD_W`, default 32: width of one dump word; must be a multiple of 8.
- `NUM_WORDS`, default 16: number of words per dump; must be at least 1.
- `CNT_W`, default 8: width of `sendCounter`.

**Ports**
- `clock`, in, 1: single clock.
- `resetGral`, in, 1: reset, synchronous, active-high.
- `rx_valid`, in, 1: one-cycle pulse; `rx_data` holds a received byte.
- `rx_data`, in, 8: received command byte.
- `tx_ready`, in, 1: UART TX idle and able to accept a byte.
- `tx_start`, out, 1: one-cycle pulse; `tx_data` is valid.
- `tx_data`, out, 8: byte to transmit.
- `halt_in`, in, 1: datapath reached its halt instruction.
- `dump_sel`, out, clog2(NUM_WORDS): word index presented to the datapath.
- `dump_data`, in, WORD_W: word selected by `dump_sel`; combinational in the datapath.
- `pipe_enable`, out, 1: pipeline clock enable.
- `ledIdle`, `ledStep`, `ledSend`, `ledCont`, out, 1 each: one-hot mode indicators.
- `sendCounter`, out, CNT_W: bytes sent in the current dump.
- `sentFlag`, out, 1: last dump completed.
- `waitingForReg`, out, 1: high while the block waits for `dump_data` to settle.

## Operation

- Command bytes: `'c'` = 0x63 (run), `'s'` = 0x73 (enter step mode), `'n'` = 0x6E (step once), `'e'` = 0x65 (exit step mode).
- **States:** IDLE, CONT, STEP, STEP_PULSE, LOAD, SEND_BYTE, WAIT_TX.
- **IDLE:**
  - `'c'` goes to CONT; `'s'` goes to STEP.
  - Any other byte is ignored.
  - Any accepted command clears `sentFlag`.
- **CONT:**
  - `pipe_enable` is 1 every cycle.
  - When `halt_in` is sampled high, `pipe_enable` is 0 from the next cycle on, and the block goes to LOAD with return target IDLE.
- **STEP:**
  - `'n'` goes to STEP_PULSE; `'e'` goes to IDLE; other bytes are ignored.
  - STEP_PULSE drives `pipe_enable` = 1 for exactly one cycle, then goes to LOAD with return target STEP.
  - If `halt_in` is already high in STEP, `'n'` still dumps but gives no enable pulse.
- **LOAD:**
  - Registers `dump_sel` = word index and asserts `waitingForReg` for 1 cycle.
  - Captures `dump_data` into a shift register on the following cycle.
- **SEND_BYTE:**
  - When `tx_ready` = 1, pulses `tx_start` with the word's current MSB byte and increments `sendCounter`.
  - Then goes to WAIT_TX.
- **WAIT_TX:**
  - Waits 1 cycle, then waits for `tx_ready` = 1.
  - Moves to the next byte (shift left by 8); after WORD_W/8 bytes, moves to the next word via LOAD.
  - After word NUM_WORDS-1: sets `sentFlag`, resets `dump_sel` to 0, and goes to the return target.
  - `sendCounter` holds its final value until the next dump starts, which clears it.
- **Byte order:** words are sent in index order 0 to NUM_WORDS-1; each word is sent MSB byte first. Total = NUM_WORDS·WORD_W/8 bytes.
- `rx_valid` in any state other than IDLE and STEP is dropped, not queued.
- `sendCounter` wraps modulo 2^CNT_W.
- **LEDs:**
  - `ledSend` is high in LOAD, SEND_BYTE and WAIT_TX.
  - `ledCont` is high in CONT; `ledStep` in STEP and STEP_PULSE; `ledIdle` in IDLE.
  - Exactly one LED is high at any time.
- **Reset:** `resetGral` high on a clock edge, including mid-dump, sets:
  - state = IDLE;
  - all outputs 0, except `ledIdle` = 1;
  - `dump_sel` = 0, `sendCounter` = 0, `sentFlag` = 0;
  - the shift register is cleared.
  - A byte already handed to the UART is not recalled.

## Timing

- A command byte on `rx_valid` at cycle t changes state at t+1; `pipe_enable` reflects the new state at t+1.
- **Step:** `'n'` at cycle t gives `pipe_enable` = 1 during t+1 only; LOAD is at t+2 and the first `tx_start` is at the earliest t+4.
- **Per word:** LOAD (1 cycle) plus capture (1 cycle) before the first byte.
- **Per byte:** `tx_start` pulse, then ≥1 cycle of WAIT_TX, then the wait on `tx_ready`.
- `tx_start` is never asserted on two consecutive cycles, and never while `tx_ready` = 0.
- **Simultaneous events:** `halt_in` and `rx_valid` together in CONT: halt wins and the byte is dropped.

## Structure

- **Shared package `debug_pkg`:** state enum, command byte constants (`CMD_RUN`, `CMD_STEP`, `CMD_NEXT`, `CMD_EXIT`), and the return-target encoding.
- **Sub-module `dump_serializer`:**
  - Handles word load, byte shift, tx handshake and the byte/word counters.
  - Started by a one-cycle `start` pulse; reports a `done` pulse.
- The top-level FSM handles mode decoding, `pipe_enable` and the LEDs.

## Test plan

All scenarios use WORD_W=32, NUM_WORDS=4 and a TX model with 10-cycle busy.

- **Step and dump:** reset, `'s'`, `'n'` with word i = 0x11223344+i. Expect exactly one `pipe_enable` cycle, then 16 bytes 11 22 33 44 11 22 33 45 … 11 22 33 47, `sendCounter` = 16, `sentFlag` = 1, `ledStep` = 1.
- **Continuous run to halt:** `'c'`, `halt_in` raised after 50 cycles. Expect `pipe_enable` high for 50 cycles and low from the cycle after halt; one 16-byte dump; then IDLE with `ledIdle` = 1.
- **Ignored bytes:** `'x'` in IDLE, and `'c'` sent during a dump. Expect no state change, the byte sequence unchanged, and no extra `tx_start`.
- **Reset mid-dump:** `resetGral` after byte 7. Expect next cycle: IDLE, `tx_start` = 0, `sendCounter` = 0, `sentFlag` = 0, `dump_sel` = 0.
- **Backpressure:** `tx_ready` held low for 100 cycles mid-word. Expect no `tx_start` while it is low, resume on the same byte, 16 bytes total.
- **Exit step mode:** `'s'`, `'e'`, `'n'`. Expect IDLE after `'e'`, and `'n'` produces no `pipe_enable` and no dump.
